// File: rtl/id_scoreboard_if.sv
// Handshake bundle between the ID stage and the load/MDU interlock scoreboard.
// The master drives the decoded-instruction fields; the slave (the scoreboard) returns the stall and issue status.
interface id_scoreboard_if #(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32
);
  logic                id_valid_i;
  logic                reg1_read_i;
  logic                reg2_read_i;
  logic [REG_AW-1:0]   reg1_addr_i;
  logic [REG_AW-1:0]   reg2_addr_i;
  logic                wreg_i;
  logic [REG_AW-1:0]   wd_i;
  logic                is_load_i;
  logic                is_mdu_i;
  logic                is_hilo_rd_i;
  logic                stall_i;
  logic                flush_i;
  logic                stall_req_o;
  logic                issue_o;
  logic                mdu_busy_o;
  logic [NUM_REGS-1:0] pending_o;

  modport master (
    output id_valid_i, reg1_read_i, reg2_read_i, reg1_addr_i, reg2_addr_i,
           wreg_i, wd_i, is_load_i, is_mdu_i, is_hilo_rd_i, stall_i, flush_i,
    input  stall_req_o, issue_o, mdu_busy_o, pending_o
  );

  modport slave (
    input  id_valid_i, reg1_read_i, reg2_read_i, reg1_addr_i, reg2_addr_i,
           wreg_i, wd_i, is_load_i, is_mdu_i, is_hilo_rd_i, stall_i, flush_i,
    output stall_req_o, issue_o, mdu_busy_o, pending_o
  );
endinterface

// File: rtl/id_scoreboard.sv
// Decode-stage interlock: per-register load countdowns plus an MDU busy countdown.
// Raises a stall request when the instruction in ID needs a result forwarding cannot yet supply.
module id_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4
) (
  input  logic          clk,
  input  logic          rst,
  id_scoreboard_if.slave sb
);
  localparam int LD_W  = $clog2(LOAD_LAT + 1);
  localparam int MDU_W = $clog2(MDU_LAT + 1);

  logic [NUM_REGS-1:0] w_pend;
  logic [MDU_W-1:0]    r_mdu_cnt;
  logic                w_raw1;
  logic                w_raw2;
  logic                w_mduh;
  logic                w_live;
  logic                w_stall_req;
  logic                w_issue;
  logic                w_ld_set;
  logic                w_mdu_set;

  // Register 0 is never tracked, so reads of it can never raise a hazard.
  assign w_pend[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : gen_ld
    logic [LD_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (!sb.stall_i) begin
        if (w_ld_set && (sb.wd_i == REG_AW'(g)))
          r_cnt <= LD_W'(LOAD_LAT);
        else if (r_cnt != '0)
          r_cnt <= r_cnt - LD_W'(1);
      end
    end

    assign w_pend[g] = (r_cnt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mdu_cnt <= '0;
    end else if (!sb.stall_i) begin
      if (w_mdu_set)
        r_mdu_cnt <= MDU_W'(MDU_LAT);
      else if (r_mdu_cnt != '0)
        r_mdu_cnt <= r_mdu_cnt - MDU_W'(1);
    end
  end

  assign w_raw1      = sb.reg1_read_i & w_pend[sb.reg1_addr_i];
  assign w_raw2      = sb.reg2_read_i & w_pend[sb.reg2_addr_i];
  assign w_mduh      = (sb.is_mdu_i | sb.is_hilo_rd_i) & (r_mdu_cnt != '0);
  assign w_live      = ~rst & sb.id_valid_i & ~sb.flush_i;
  assign w_stall_req = w_live & (w_raw1 | w_raw2 | w_mduh);
  assign w_issue     = w_live & ~sb.stall_i & ~w_stall_req;

  // Only issued instructions arm counters; a flushed or stalled load leaves no trace.
  assign w_ld_set  = w_issue & sb.is_load_i & sb.wreg_i & (sb.wd_i != '0);
  assign w_mdu_set = w_issue & sb.is_mdu_i;

  assign sb.stall_req_o = w_stall_req;
  assign sb.issue_o     = w_issue;
  assign sb.mdu_busy_o  = ~rst & (r_mdu_cnt != '0);
  assign sb.pending_o   = rst ? '0 : w_pend;
endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: a countdown reference model predicts outputs per cycle,
// expectations are queued at drive time and compared when the DUT outputs settle.
module tb_id_scoreboard;
  localparam int LL = 2;
  localparam int ML = 4;

  typedef struct packed {
    logic       rst, v, r1, r2;
    logic [4:0] a1, a2;
    logic       w;
    logic [4:0] wd;
    logic       ld, mdu, hr, st, fl;
  } in_t;

  typedef struct packed {
    logic        sr, iss, busy;
    logic [31:0] pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_scoreboard_if #(.REG_AW(5), .NUM_REGS(32)) sbif ();

  id_scoreboard #(.REG_AW(5), .NUM_REGS(32), .LOAD_LAT(LL), .MDU_LAT(ML)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  int   ldm[32];
  int   mm;
  logic        last_sr, last_iss, last_busy;
  logic [31:0] last_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic in_t f_nop();
    in_t x;
    x = '0;
    return x;
  endfunction

  function automatic in_t f_lw(input logic [4:0] rd);
    in_t x;
    x = '0; x.v = 1'b1; x.w = 1'b1; x.wd = rd; x.ld = 1'b1;
    return x;
  endfunction

  function automatic in_t f_use(input logic [4:0] a);
    in_t x;
    x = '0; x.v = 1'b1; x.r1 = 1'b1; x.a1 = a; x.w = 1'b1; x.wd = 5'd10;
    return x;
  endfunction

  function automatic in_t f_mult();
    in_t x;
    x = '0; x.v = 1'b1; x.r1 = 1'b1; x.a1 = 5'd11; x.r2 = 1'b1; x.a2 = 5'd12; x.mdu = 1'b1;
    return x;
  endfunction

  function automatic in_t f_mflo();
    in_t x;
    x = '0; x.v = 1'b1; x.hr = 1'b1; x.w = 1'b1; x.wd = 5'd8;
    return x;
  endfunction

  task automatic step(input in_t x);
    exp_t e;
    exp_t got;
    logic raw1, raw2, mduh;
    rst                = x.rst;
    sbif.id_valid_i    = x.v;
    sbif.reg1_read_i   = x.r1;
    sbif.reg2_read_i   = x.r2;
    sbif.reg1_addr_i   = x.a1;
    sbif.reg2_addr_i   = x.a2;
    sbif.wreg_i        = x.w;
    sbif.wd_i          = x.wd;
    sbif.is_load_i     = x.ld;
    sbif.is_mdu_i      = x.mdu;
    sbif.is_hilo_rd_i  = x.hr;
    sbif.stall_i       = x.st;
    sbif.flush_i       = x.fl;
    raw1   = x.r1 && (ldm[x.a1] != 0);
    raw2   = x.r2 && (ldm[x.a2] != 0);
    mduh   = (x.mdu || x.hr) && (mm != 0);
    e.sr   = !x.rst && x.v && !x.fl && (raw1 || raw2 || mduh);
    e.iss  = !x.rst && x.v && !x.fl && !x.st && !e.sr;
    e.busy = !x.rst && (mm != 0);
    for (int r = 0; r < 32; r++) e.pend[r] = !x.rst && (ldm[r] != 0);
    q.push_back(e);
    #4;
    got = q.pop_front();
    chk("stall_req", 32'(sbif.stall_req_o), 32'(got.sr));
    chk("issue", 32'(sbif.issue_o), 32'(got.iss));
    chk("mdu_busy", 32'(sbif.mdu_busy_o), 32'(got.busy));
    chk("pending", sbif.pending_o, got.pend);
    last_sr   = sbif.stall_req_o;
    last_iss  = sbif.issue_o;
    last_busy = sbif.mdu_busy_o;
    last_pend = sbif.pending_o;
    if (x.rst) begin
      for (int r = 0; r < 32; r++) ldm[r] = 0;
      mm = 0;
    end else if (!x.st) begin
      for (int r = 0; r < 32; r++) if (ldm[r] != 0) ldm[r]--;
      if (mm != 0) mm--;
      if (e.iss && x.ld && x.w && x.wd != 5'd0) ldm[x.wd] = LL;
      if (e.iss && x.mdu) mm = ML;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t x;
    int  n, k, first_iss;
    for (int r = 0; r < 32; r++) ldm[r] = 0;
    mm = 0;

    // reset with garbage on the inputs: every output must read 0
    x = f_use(5'd3); x.rst = 1'b1; x.ld = 1'b1; x.mdu = 1'b1;
    step(x);
    step(x);
    chk("rst_issue", 32'(last_iss), 32'd0);
    step(f_nop());

    // load-use: dependent op stalls exactly LL cycles
    step(f_lw(5'd5));
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(f_use(5'd5));
      if (last_sr) n++;
      if (last_iss) break;
    end
    chk("ld_stall_len", n, LL);
    chk("ld_use_issued", 32'(last_iss), 32'd1);

    // downstream stall extends the countdown
    step(f_lw(5'd7));
    n = 0; first_iss = 0;
    for (k = 1; k <= 12; k++) begin
      x = f_use(5'd7);
      if (k <= 2) x.st = 1'b1;
      step(x);
      if (last_pend[7]) n++;
      if (last_iss) begin first_iss = k; break; end
    end
    chk("stall_pend_len", n, LL + 2);
    chk("stall_issue_cyc", first_iss, LL + 3);

    // r0 is never tracked
    step(f_lw(5'd0));
    step(f_use(5'd0));
    chk("r0_no_stall", 32'(last_sr), 32'd0);
    chk("r0_pending", last_pend, 32'd0);

    // MULT then MFLO: held ML cycles, busy drops with the stall
    step(f_mult());
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step(f_mflo());
      if (last_sr) n++;
      if (last_iss) break;
    end
    chk("mdu_stall_len", n, ML);
    chk("mdu_busy_at_issue", 32'(last_busy), 32'd0);

    // flushed load never arms a counter
    x = f_lw(5'd3); x.fl = 1'b1;
    step(x);
    chk("flush_issue", 32'(last_iss), 32'd0);
    step(f_use(5'd3));
    chk("flush_pend3", 32'(last_pend[3]), 32'd0);

    // reset mid-operation discards pending state
    step(f_lw(5'd3));
    step(f_lw(5'd7));
    step(f_nop());
    chk("pend_pre_rst", last_pend, 32'h0000_0088);
    x = f_use(5'd3); x.rst = 1'b1;
    step(x);
    chk("pend_in_rst", last_pend, 32'd0);
    step(f_use(5'd7));
    chk("stall_post_rst", 32'(last_sr), 32'd0);

    // back-to-back loads to the same register re-arm the counter
    n = 0;
    step(f_lw(5'd9));
    if (last_pend[9]) n++;
    step(f_lw(5'd9));
    if (last_pend[9]) n++;
    for (int i = 0; i < 6; i++) begin
      step(f_nop());
      if (last_pend[9]) n++;
    end
    chk("rearm_len", n, LL + 1);

    // random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      x       = '0;
      x.rst   = ($urandom_range(0, 59) == 0);
      x.v     = ($urandom_range(0, 3) != 0);
      x.r1    = $urandom_range(0, 1);
      x.r2    = $urandom_range(0, 1);
      x.a1    = 5'($urandom_range(0, 7));
      x.a2    = 5'($urandom_range(0, 7));
      x.w     = $urandom_range(0, 1);
      x.wd    = 5'($urandom_range(0, 7));
      x.ld    = ($urandom_range(0, 2) == 0);
      x.mdu   = ($urandom_range(0, 7) == 0);
      x.hr    = ($urandom_range(0, 5) == 0);
      x.st    = ($urandom_range(0, 7) == 0);
      x.fl    = ($urandom_range(0, 9) == 0);
      step(x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised decode-stage interlock unit for the five-stage MIPS pipeline. It sits beside the ID stage and tracks in-flight load destinations and the busy state of a multi-cycle multiply/divide unit (MDU), using per-register countdown counters. It raises a stall request whenever the instruction in ID would consume a result that EX/MEM forwarding cannot yet supply. It generalises the fixed ex/mem forwarding in ID with configurable load latency, MDU latency and register-file size.

## Interface
Parameters:
- REG_AW, 5, register address width
- NUM_REGS, 32, number of architectural registers; must equal 2^REG_AW
- LOAD_LAT, 1, cycles after issue before a load result becomes forwardable; range 1..7
- MDU_LAT, 4, cycles the MDU stays busy after a mult/div issues; range 1..31

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1)
- id_valid_i  in  1  ID holds a valid decoded instruction
- reg1_read_i  in  1  instruction reads reg1_addr_i
- reg2_read_i  in  1  instruction reads reg2_addr_i
- reg1_addr_i  in  REG_AW  first source register
- reg2_addr_i  in  REG_AW  second source register
- wreg_i  in  1  instruction writes a register
- wd_i  in  REG_AW  destination register
- is_load_i  in  1  instruction is a load (LB/LW class)
- is_mdu_i  in  1  instruction starts an MDU operation (MULT/DIV class)
- is_hilo_rd_i  in  1  instruction reads HI/LO (MFHI/MFLO)
- stall_i  in  1  downstream (EX or later) stall; pipeline frozen
- flush_i  in  1  kill the instruction currently in ID
- stall_req_o  out  1  ID stall request to the ctrl block
- issue_o  out  1  instruction leaves ID this cycle
- mdu_busy_o  out  1  MDU counter is nonzero
- pending_o  out  NUM_REGS  bit r set while register r has a nonzero load counter

## Operation
- State:
  - ld_cnt[r] for r = 1..NUM_REGS-1, width clog2(LOAD_LAT+1); ld_cnt[0] is constant 0.
  - mdu_cnt, width clog2(MDU_LAT+1).
- Hazard, evaluated combinationally from current state and inputs:
  - raw1 = reg1_read_i & ld_cnt[reg1_addr_i] != 0
  - raw2 = reg2_read_i & ld_cnt[reg2_addr_i] != 0
  - mduh = (is_mdu_i | is_hilo_rd_i) & mdu_cnt != 0
  - stall_req_o = id_valid_i & ~flush_i & (raw1 | raw2 | mduh)
- Issue:
  - issue_o = id_valid_i & ~flush_i & ~stall_i & ~stall_req_o.
- Per-cycle counter update, when stall_i = 0:
  - Every nonzero ld_cnt decrements by 1, and mdu_cnt decrements by 1 if nonzero.
  - Then, if issue_o & is_load_i & wreg_i & wd_i != 0, ld_cnt[wd_i] is loaded with LOAD_LAT. The load takes priority over the decrement of the same entry, which re-arms a register already pending.
  - If issue_o & is_mdu_i, mdu_cnt is loaded with MDU_LAT.
- When stall_i = 1, all counters hold and nothing issues.
- Flush affects only the instruction currently in ID. Counters of already-issued loads and MDU ops keep counting. A flushed load never sets a counter.
- Writes to register 0 are never tracked. Reads of register 0 never stall.
- pending_o[r] = (ld_cnt[r] != 0); mdu_busy_o = (mdu_cnt != 0).

## Timing
- Reset: every ld_cnt and mdu_cnt is cleared to 0 at the first clock edge with rst = 1. While rst = 1, all outputs are 0: stall_req_o, issue_o, mdu_busy_o and pending_o all read 0. Reset mid-operation discards all pending state.
- stall_req_o and issue_o are combinational outputs; they carry no register delay.
- Load at edge t:
  - pending_o[wd] is 1 from t+1 through t+LOAD_LAT, assuming stall_i = 0 throughout.
  - A dependent instruction stalls for exactly LOAD_LAT cycles and issues in cycle t+LOAD_LAT+1.
- MDU op at edge t:
  - mdu_busy_o is 1 for MDU_LAT cycles.
  - A following MFHI/MFLO or MDU op is held MDU_LAT cycles.
- Each stall_i cycle extends every countdown by one cycle.
- Simultaneous reg1 and reg2 hazards give a single stall_req_o; the stall lasts until the later counter expires.

## Test plan
- LOAD_LAT=1: LW to r5 issues at cycle 0; ADD reading r5 presented at cycle 1 -> stall_req_o=1 for exactly 1 cycle, issue_o=1 at cycle 2, pending_o[5] high only during cycle 1.
- LOAD_LAT=3: LW to r7, then stall_i=1 for 2 cycles -> pending_o[7] high for 5 cycles; the dependent instruction issues on the 6th cycle.
- LW to r0, followed by an instruction reading r0 -> no stall, pending_o == 0.
- MDU_LAT=4: MULT issues, then MFLO presented the next cycle -> stall_req_o=1 for 4 cycles, mdu_busy_o falls together with the stall.
- LW to r3 presented with flush_i=1 -> issue_o=0 and pending_o[3] stays 0. Separately, rst=1 while pending_o=0x0000_0088 -> all outputs 0 after the edge.
- Two LWs to r9 issued back-to-back (LOAD_LAT=2) -> the counter re-arms to 2 and pending_o[9] stays high for 3 consecutive cycles.
